// File: rtl/lib_voq_pkg.sv
// lib_voq_pkg: shared constants and helpers for the lib_voq_gen virtual output queue.
//   STALL_W    : width of each per-channel stall counter
//   cnt_width  : bits needed to hold an occupancy value of 0..DEPTH
//   is_onehot  : true when exactly one bit of a (zero-extended) vector is set
package lib_voq_pkg;

  localparam int STALL_W = 16;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Callers zero-extend their vector to 32 bits. Zero-extension does not
  // change how many bits are set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/lib_voq_gen_if.sv
// lib_voq_gen_if: upstream/arbiter-facing bus of the VOQ.
//   master : upstream link + arbiter side (drives data, write request, pop select)
//   slave  : the VOQ itself
// Vectors declared [0:M-1] carry channel 0 in their leftmost (MS) bit.
// o_count and o_stall_cnt are flat vectors with channel 0 in the MS field.
interface lib_voq_gen_if
  import lib_voq_pkg::*;
#(
  parameter int M     = 5,
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0]     i_data;
  logic [0:M-1]         i_data_val;
  logic                 o_en;
  logic [WIDTH-1:0]     o_data;
  logic [0:M-1]         o_data_val;
  logic [0:M-1]         i_en;
  logic [M*CW-1:0]      o_count;
  logic [0:M-1]         o_near_full;
  logic [M*STALL_W-1:0] o_stall_cnt;

  modport master (
    output i_data, i_data_val, i_en,
    input  o_en, o_data, o_data_val, o_count, o_near_full, o_stall_cnt
  );

  modport slave (
    input  i_data, i_data_val, i_en,
    output o_en, o_data, o_data_val, o_count, o_near_full, o_stall_cnt
  );
endinterface

// File: rtl/lib_voq_chan.sv
// lib_voq_chan: one circular first-word-fall-through FIFO channel.
//   clk, reset_n : clock, asynchronous active-low reset
//   ce           : clock enable gating every state update
//   wr, din      : write request and data (refused when full)
//   rd           : pop request (ignored when empty)
//   dout         : head entry, combinational from the read pointer
//   count        : occupancy 0..DEPTH
//   full, empty, near_full : status derived from count only
module lib_voq_chan
  import lib_voq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 64,
  parameter int NEAR_FULL = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ce,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        near_full
);
  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_wr;
  logic             do_rd;

  // Fullness is judged before this cycle's pop, so a write racing a pop on a
  // full channel is refused while the pop still happens.
  assign do_wr = ce & wr & ~full;
  assign do_rd = ce & rd & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= din;
  end

  assign dout      = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign near_full = (count_reg >= CW'(NEAR_FULL));

endmodule

// File: rtl/lib_voq_gen.sv
// lib_voq_gen: M-channel virtual output queue between an upstream link and
// the switch arbiter of a router input port.
//   clk, reset_n : clock, asynchronous active-low reset
//   ce           : clock enable; o_en is forced low while ce=0
//   bus (slave)  : i_data/i_data_val write side, o_en upstream enable,
//                  i_en pop select, o_data head of the selected channel,
//                  o_data_val/o_count/o_near_full per-channel status,
//                  o_stall_cnt per-channel refused-write counters
// Optional feature macro: LIB_VOQ_STALL_CNT_EN enables the saturating stall
// counters; without it o_stall_cnt is tied to zero.
module lib_voq_gen
  import lib_voq_pkg::*;
#(
  parameter int M         = 5,
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 64,
  parameter int NEAR_FULL = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  lib_voq_gen_if.slave  bus
);
  localparam int CW = cnt_width(DEPTH);

  logic                 wr_ok;
  logic                 rd_ok;
  logic [0:M-1]         wr_vec;
  logic [0:M-1]         rd_vec;
  logic [0:M-1]         full_vec;
  logic [0:M-1]         empty_vec;
  logic [0:M-1]         near_full_vec;
  logic [WIDTH-1:0]     dout [M];
  logic [M*CW-1:0]      count_flat;
  logic [M*STALL_W-1:0] stall_flat;
  logic [WIDTH-1:0]     data_mux;

  // Zero or multi-hot vectors behave as "no request".
  assign wr_ok  = is_onehot(32'(bus.i_data_val));
  assign rd_ok  = is_onehot(32'(bus.i_en));
  // reset_n in the write gate keeps a write from landing while reset is held.
  assign wr_vec = (wr_ok && reset_n) ? bus.i_data_val : '0;
  assign rd_vec = rd_ok ? bus.i_en : '0;

  assign bus.o_en = reset_n & ce & wr_ok & (|(bus.i_data_val & ~full_vec));

  for (genvar gi = 0; gi < M; gi++) begin : g_chan
    lib_voq_chan #(
      .DEPTH     (DEPTH),
      .WIDTH     (WIDTH),
      .NEAR_FULL (NEAR_FULL)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (ce),
      .wr        (wr_vec[gi]),
      .rd        (rd_vec[gi]),
      .din       (bus.i_data),
      .dout      (dout[gi]),
      .count     (count_flat[(M-1-gi)*CW +: CW]),
      .full      (full_vec[gi]),
      .empty     (empty_vec[gi]),
      .near_full (near_full_vec[gi])
    );
  end

  // Output mux; with no valid select the bus is driven to zero.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < M; i++) begin
      if (rd_vec[i]) data_mux = dout[i];
    end
  end

`ifdef LIB_VOQ_STALL_CNT_EN
  for (genvar gi = 0; gi < M; gi++) begin : g_stall
    logic [STALL_W-1:0] stall_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stall_reg <= '0;
      end else if (ce && wr_vec[gi] && full_vec[gi] && (stall_reg != '1)) begin
        stall_reg <= stall_reg + STALL_W'(1);
      end
    end
    assign stall_flat[(M-1-gi)*STALL_W +: STALL_W] = stall_reg;
  end
`else
  assign stall_flat = '0;
`endif

  assign bus.o_data      = data_mux;
  assign bus.o_data_val  = ~empty_vec;
  assign bus.o_count     = count_flat;
  assign bus.o_near_full = near_full_vec;
  assign bus.o_stall_cnt = stall_flat;

endmodule

// File: doc/lib_voq_gen.md
Name: lib_voq_gen

Overview:
Parametrised virtual output queue, the next generation of the router input VOQ.
- M independent circular FIFO channels, each with an occupancy counter and a near-full flag for upstream credit/threshold flow control.
- Generic data width replaces the fixed packet type.
- Sits between an upstream link and the switch/arbiter of a router input port.

Parameters:
M, 5, number of output ports / virtual channels (>=2)
DEPTH, 4, entries per channel (>=2, power of two)
WIDTH, 64, data bits per entry
NEAR_FULL, 3, occupancy at or above which o_near_full[i] asserts (1..DEPTH)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; all state updates gated by ce
i_data  in  WIDTH  upstream data, common to all channels
i_data_val  in  [0:M-1]  onehot write request; bit i = destined for output i
o_en  out  1  upstream enable: the addressed channel can accept
o_data  out  WIDTH  head entry of the channel selected by i_en
o_data_val  out  [0:M-1]  bit i = channel i non-empty
i_en  in  [0:M-1]  onehot pop/select from the arbiter
o_count  out  M*$clog2(DEPTH+1)  per-channel occupancy; channel 0 in the MS field
o_near_full  out  [0:M-1]  bit i = count[i] >= NEAR_FULL
o_stall_cnt  out  M*16  per-channel stall counters (see Optional Feature)

Behaviour:
- Bit 0 of every [0:M-1] vector is the leftmost (MSB) bit.
- Reset (async assert, sync release): all pointers and counts = 0; o_data_val=0, o_near_full=0, o_count=0, o_stall_cnt=0. o_en=0 while reset_n low.
- Onehot check: i_data_val and i_en are valid only when exactly one bit is set; zero or multi-hot vectors are treated as "none".
- o_en (combinational):
  - =1 iff ce=1, i_data_val is onehot, and the addressed channel has count<DEPTH.
  - =0 otherwise.
- Write: on a clock edge with ce=1, i_data_val onehot on channel i, and channel i not full, i_data is stored at wr_ptr[i]; wr_ptr[i] increments and wraps mod DEPTH.
  - Non-onehot i_data_val: no write; no state change in any channel.
- Read (first-word-fall-through):
  - o_data = mem[i][rd_ptr[i]] when i_en is onehot on channel i; otherwise o_data=0 (never 'z).
  - Pop on a clock edge with ce=1, i_en onehot on channel i, and o_data_val[i]=1; rd_ptr[i] increments and wraps.
  - i_en on an empty channel: no pop, o_data undefined-but-driven (stale mem). Non-onehot i_en: no pop.
- Latency: a write into an empty channel makes o_data_val[i]=1 on the next cycle, with o_data valid when selected.
- Simultaneous write and pop:
  - Same channel, not full: both occur, count unchanged.
  - Same channel, full: pop occurs, write refused (o_en was 0), count-1.
  - Different channels: independent.
- Count: next = count + wr - rd, range 0..DEPTH, never wraps. o_data_val[i] = (count[i]!=0). o_near_full is registered-derived from count (no input dependency).
- ce=0: all state frozen; o_en=0; o_data, o_data_val and o_count still reflect the current state.
- Reset mid-operation: contents are discarded immediately, with no partial write.

Optional Feature:
LIB_VOQ_STALL_CNT_EN
- Defined:
  - Each channel has a 16-bit saturating counter.
  - It increments on a ce=1 edge when i_data_val is onehot on that channel and the channel is full (write refused).
  - It saturates at 16'hFFFF and clears only on reset.
  - Output on o_stall_cnt.
- Undefined: o_stall_cnt tied to 0 and no counter logic is generated.

Decomposition:
- Shared package lib_voq_pkg:
  - localparam function for count width ($clog2(DEPTH+1)).
  - onehot-check function.
  - Stall counter width constant (16).
- One natural sub-module, lib_voq_chan: a single-channel circular FIFO exposing wr, rd, din, dout, count, full, empty and near_full. Instantiated M times in a generate loop. The top level holds the onehot decode, the output mux and the optional stall counters.

Test Plan (M=4, DEPTH=4, WIDTH=8, NEAR_FULL=3 unless stated):
- Reset check: hold reset_n=0 with i_data_val=4'b1000 -> o_en=0, o_data_val=0, all counts 0. Release -> o_en=1 next evaluation.
- Fill ch1: write 0xA1..0xA4 with i_data_val=4'b0100:
  - o_near_full[1] rises after the 3rd write.
  - After the 4th, count=4 and o_en=0.
  - A 5th write is refused and contents are unchanged.
- Drain ch1: set i_en=4'b0100 for 4 cycles -> o_data reads 0xA1,0xA2,0xA3,0xA4 in order, then o_data_val[1]=0, count=0. Pointer wrap verified by refilling with 0xB1..0xB4 and reading them back.
- Simultaneous: ch2 at count 2, write 0xC3 and pop in the same cycle -> count stays 2, head advances. Ch3 full with write+pop -> count 3, write refused.
- Illegal vectors: i_data_val=4'b0110 or i_en=4'b1001 -> no write/pop anywhere, o_en=0, o_data=0.
- Stall counter (with LIB_VOQ_STALL_CNT_EN, ce toggled): ch0 full, 10 refused write attempts with ce=1 plus 5 with ce=0 -> stall_cnt[0]=10. Force 70000 refusals -> saturates at 16'hFFFF. Without the macro -> o_stall_cnt=0.
